// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage; also imported by the PC and decode blocks.
package instr_fetch_pkg;

    localparam int FETCH_ADDR_W  = 36;
    localparam int FETCH_INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC block, instruction memory and decode-side signals.
//
// Handshakes:
//   memory : o_mem_req is held with a stable o_mem_addr until i_mem_ack is seen
//            high; i_mem_rdata is valid in the ack cycle. A started read is
//            always completed, never withdrawn (only reset drops it).
//   decode : an instruction moves on a rising edge where o_valid && i_ready;
//            o_instr/o_instr_pc stay stable while o_valid is high and not taken.
interface instr_fetch_if import instr_fetch_pkg::*; #(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
) ();

    logic               i_en;
    logic [ADDR_W-1:0]  i_pc;
    logic               o_pc_advance;
    logic               i_redirect;
    logic               o_mem_req;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic               i_mem_ack;
    logic [INSTR_W-1:0] i_mem_rdata;
    logic               o_valid;
    logic               i_ready;
    logic [INSTR_W-1:0] o_instr;
    logic [ADDR_W-1:0]  o_instr_pc;

    // The fetch stage itself.
    modport master (
        input  i_en, i_pc, i_redirect, i_mem_ack, i_mem_rdata, i_ready,
        output o_pc_advance, o_mem_req, o_mem_addr, o_valid, o_instr, o_instr_pc
    );

    // The surroundings: PC block, memory and decode.
    modport slave (
        output i_en, i_pc, i_redirect, i_mem_ack, i_mem_rdata, i_ready,
        input  o_pc_advance, o_mem_req, o_mem_addr, o_valid, o_instr, o_instr_pc
    );

endinterface

// File: rtl/instr_fetch_buf.sv
// Single-entry instruction/PC buffer presented to decode with valid/ready.
module instr_fetch_buf import instr_fetch_pkg::*; #(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_load_instr,
    input  logic [ADDR_W-1:0]  i_load_pc,
    input  logic               i_ready,
    input  logic               i_flush,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_instr_pc
);

    // Load only into an empty slot; empty it on a decode take or a flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_instr    <= '0;
            o_instr_pc <= '0;
        end else if (i_load && !o_valid) begin
            o_valid    <= 1'b1;
            o_instr    <= i_load_instr;
            o_instr_pc <= i_load_pc;
        end else if (o_valid && (i_ready || i_flush)) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: request a word at the current PC, buffer it for decode,
// strobe the PC forward, and squash fetches made stale by a redirect.
module instr_fetch import instr_fetch_pkg::*; #(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    instr_fetch_if.master bus,
    output fetch_state_e  o_dbg_state
);

    fetch_state_e      state;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              take_ack;

    // A fetch is kept when its ack lands in REQ with no redirect alongside it.
    // The advance strobe is driven straight from this so the PC has already
    // stepped by the next edge, where a back-to-back REQ latches i_pc.
    assign take_ack = (state == REQ) && bus.i_mem_ack && !bus.i_redirect;

    // Fetch sequencing; o_mem_req/o_mem_addr are registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_en && !bus.i_redirect) begin
                        state      <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= bus.i_pc;
                    end
                end
                REQ: begin
                    if (bus.i_mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= bus.i_redirect ? IDLE : HOLD;
                    end else if (bus.i_redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.i_mem_ack) begin
                        mem_req_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                HOLD: begin
                    if (bus.i_redirect) begin
                        state <= IDLE;
                    end else if (bus.i_ready) begin
                        if (bus.i_en) begin
                            state      <= REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= bus.i_pc;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    instr_fetch_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (take_ack),
        .i_load_instr (bus.i_mem_rdata),
        .i_load_pc    (mem_addr_q),
        .i_ready      (bus.i_ready),
        .i_flush      (bus.i_redirect),
        .o_valid      (bus.o_valid),
        .o_instr      (bus.o_instr),
        .o_instr_pc   (bus.o_instr_pc)
    );

    assign bus.o_mem_req    = mem_req_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_pc_advance = take_ack;
    assign o_dbg_state      = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic,
// with a program-flow reference model and a delivery scoreboard.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int AW = 36;
    localparam int IW = 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    fetch_state_e dbg_state;

    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [AW+IW-1:0] exp_q[$];

    // reference model: architectural next-fetch PC and memory transaction view
    logic [AW-1:0] model_pc = '0;
    logic [AW-1:0] next_pc  = '0;
    logic [AW-1:0] txn_addr = '0;
    bit in_txn = 0;
    bit live   = 0;
    int wait_cnt = 0;
    int ack_dly  = 0;
    int cur_dly  = 1;

    // monitor history
    bit prev_valid = 0;
    bit prev_left  = 0;
    logic [IW-1:0] prev_instr = '0;
    logic [AW-1:0] prev_pc    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // memory contents as a pure function of the word address
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] lo;
        logic [31:0] mix;
        lo  = a[31:0];
        mix = lo * 32'h9E37_79B1;
        return 32'hA000_0000 ^ mix ^ {28'd0, a[35:32]};
    endfunction

    // ---------------- driver ----------------
    // One clock cycle: PC block, decode and memory behaviour plus model update.
    // force_ack: -1 = memory acks after its chosen delay, 0 = no ack, 1 = ack now.
    task automatic step(input bit en, input bit rdy, input bit redir,
                        input logic [AW-1:0] tgt, input int force_ack);
        bit ack;
        bit exp_adv;
        @(negedge clk);
        bus.i_pc       = next_pc;
        bus.i_en       = en;
        bus.i_ready    = rdy;
        bus.i_redirect = redir;
        ack = 1'b0;
        if (bus.o_mem_req) begin
            if (!in_txn) begin
                in_txn   = 1;
                live     = 1;
                wait_cnt = 0;
                ack_dly  = cur_dly;
                txn_addr = bus.o_mem_addr;
                check("req_addr", 64'(bus.o_mem_addr), 64'(model_pc));
            end else begin
                check("addr_stable", 64'(bus.o_mem_addr), 64'(txn_addr));
            end
            if (force_ack < 0) ack = (wait_cnt >= ack_dly);
            else               ack = (force_ack != 0);
        end
        bus.i_mem_ack   = ack;
        bus.i_mem_rdata = ack ? mem_word(bus.o_mem_addr) : IW'($urandom());
        if (redir) live = 0;
        exp_adv = ack && live;
        #1;
        check("pc_advance", 64'(bus.o_pc_advance), 64'(exp_adv));
        check("req_valid_excl", 64'(bus.o_mem_req && bus.o_valid), 64'(0));
        if (redir) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            model_pc = tgt;
        end
        if (ack && live) begin
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc = model_pc + 1;
        end
        if (ack) in_txn = 0;
        else if (in_txn) wait_cnt++;
        // behavioural PC block reacting to the DUT strobe
        next_pc = redir ? tgt : (bus.o_pc_advance ? bus.i_pc + 1 : bus.i_pc);
    endtask

    task automatic run_until(input bit want_valid, input bit en, input bit rdy, input int max);
        bit hit;
        hit = 0;
        for (int i = 0; i < max && !hit; i++) begin
            step(en, rdy, 1'b0, '0, -1);
            hit = want_valid ? bus.o_valid : bus.o_mem_req;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL wait_%s: not seen within %0d cycles", want_valid ? "valid" : "req", max);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n          = 1'b0;
        bus.i_en       = 1'b0;
        bus.i_redirect = 1'b0;
        bus.i_mem_ack  = 1'b0;
        bus.i_ready    = 1'b0;
        #1;
        check("rst_mem_req",    64'(bus.o_mem_req),    64'(0));
        check("rst_mem_addr",   64'(bus.o_mem_addr),   64'(0));
        check("rst_valid",      64'(bus.o_valid),      64'(0));
        check("rst_instr",      64'(bus.o_instr),      64'(0));
        check("rst_instr_pc",   64'(bus.o_instr_pc),   64'(0));
        check("rst_pc_advance", 64'(bus.o_pc_advance), 64'(0));
        check("rst_state",      64'(dbg_state),        64'(IDLE));
        exp_q.delete();
        in_txn   = 0;
        live     = 0;
        model_pc = '0;
        next_pc  = '0;
        bus.i_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_valid = 0;
                prev_left  = 0;
            end else begin
                if (prev_valid && !prev_left) begin
                    check("valid_held",   64'(bus.o_valid),    64'(1));
                    check("instr_stable", 64'(bus.o_instr),    64'(prev_instr));
                    check("pc_stable",    64'(bus.o_instr_pc), 64'(prev_pc));
                end else if (prev_left) begin
                    check("valid_drop", 64'(bus.o_valid), 64'(0));
                end
                if (bus.o_valid && bus.i_ready && !bus.i_redirect) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL deliver: unexpected instr %0h pc %0h", bus.o_instr, bus.o_instr_pc);
                    end else begin
                        logic [AW+IW-1:0] e;
                        e = exp_q.pop_front();
                        check("deliver_pc",    64'(bus.o_instr_pc), 64'(e[AW+IW-1:IW]));
                        check("deliver_instr", 64'(bus.o_instr),    64'(e[IW-1:0]));
                    end
                end
                prev_left  = bus.o_valid && (bus.i_ready || bus.i_redirect);
                prev_valid = bus.o_valid;
                prev_instr = bus.o_instr;
                prev_pc    = bus.o_instr_pc;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] t;
        bus.i_en        = 1'b0;
        bus.i_pc        = '0;
        bus.i_redirect  = 1'b0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        bus.i_ready     = 1'b0;
        do_reset();

        // first fetch at PC 0, ack one cycle after the request
        cur_dly = 1;
        run_until(1'b1, 1'b1, 1'b0, 10);
        check("tp1_instr",    64'(bus.o_instr),    64'(32'hA000_0000));
        check("tp1_instr_pc", 64'(bus.o_instr_pc), 64'(0));

        // decode stalls 4 cycles, then takes it; next fetch must be PC 1
        repeat (4) step(1'b1, 1'b0, 1'b0, '0, -1);
        cur_dly = 3;
        step(1'b1, 1'b1, 1'b0, '0, -1);

        // redirect in the first REQ cycle, ack three cycles later is dropped
        step(1'b1, 1'b0, 1'b1, 36'h40, -1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, -1);
            check("drain_no_valid", 64'(bus.o_valid), 64'(0));
        end
        cur_dly = 2;
        run_until(1'b1, 1'b1, 1'b0, 12);
        step(1'b1, 1'b1, 1'b0, '0, -1);

        // redirect and ack in the same cycle
        cur_dly = 10;
        run_until(1'b0, 1'b1, 1'b1, 20);
        step(1'b1, 1'b1, 1'b1, 36'h123, 1);
        step(1'b1, 1'b0, 1'b0, '0, -1);
        check("redir_ack_no_valid", 64'(bus.o_valid), 64'(0));
        cur_dly = 0;
        run_until(1'b1, 1'b1, 1'b0, 10);
        step(1'b1, 1'b1, 1'b0, '0, -1);

        // redirect while holding with ready high: not delivered
        run_until(1'b1, 1'b1, 1'b0, 10);
        step(1'b1, 1'b1, 1'b1, 36'h80, -1);
        step(1'b1, 1'b0, 1'b0, '0, -1);
        check("redir_hold_drop", 64'(bus.o_valid), 64'(0));
        run_until(1'b1, 1'b1, 1'b0, 10);
        step(1'b1, 1'b1, 1'b0, '0, -1);

        // reset in the middle of an outstanding request
        cur_dly = 10;
        run_until(1'b0, 1'b1, 1'b0, 20);
        check("pre_reset_req", 64'(bus.o_mem_req), 64'(1));
        do_reset();
        cur_dly = 1;
        run_until(1'b1, 1'b1, 1'b0, 10);
        check("post_reset_pc", 64'(bus.o_instr_pc), 64'(0));
        step(1'b1, 1'b1, 1'b0, '0, -1);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            t[31:0]  = $urandom();
            t[35:32] = 4'($urandom_range(0, 15));
            cur_dly  = $urandom_range(0, 3);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, t, -1);
        end

        // quiesce: finish any outstanding fetch and let decode drain it
        cur_dly = 0;
        repeat (12) step(1'b0, 1'b1, 1'b0, '0, -1);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        check("final_valid",       64'(bus.o_valid),   64'(0));
        check("final_req",         64'(bus.o_mem_req), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage that sits between the program counter and the decode stage. It reads the current PC value, issues a word read to instruction memory over a req/ack handshake, and buffers the returned instruction and its PC. It hands them to decode over a valid/ready handshake, strobes the PC to advance, and handles branch redirects by discarding stale fetches.

Parameters:
ADDR_W, 36, PC / instruction memory address width (matches PC o_pc width)
INSTR_W, 32, instruction word width

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  fetch enable; low blocks new memory requests
i_pc  input  ADDR_W  current PC value from the PC block
o_pc_advance  output  1  one-cycle pulse; PC increments by 1 on the next edge
i_redirect  input  1  one-cycle branch/flush pulse; PC block loads target the same edge
o_mem_req  output  1  memory read request, held until acknowledged
o_mem_addr  output  ADDR_W  read address, stable while o_mem_req=1
i_mem_ack  input  1  memory acknowledge; i_mem_rdata valid in the same cycle
i_mem_rdata  input  INSTR_W  read data
o_valid  output  1  instruction buffer holds a valid instruction
i_ready  input  1  decode accepts the instruction
o_instr  output  INSTR_W  buffered instruction
o_instr_pc  output  ADDR_W  PC of the buffered instruction

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, discard=0, and every output is 0: o_mem_req, o_mem_addr, o_valid, o_instr, o_instr_pc, o_pc_advance.
- FSM states: IDLE, REQ, HOLD, DRAIN.
- IDLE:
  - If i_en=1 and i_redirect=0, go to REQ and latch o_mem_addr<=i_pc.
  - Otherwise stay in IDLE.
- REQ:
  - o_mem_req=1. o_mem_addr must not change until ack.
  - On i_mem_ack=1 with i_redirect=0: o_instr<=i_mem_rdata, o_instr_pc<=o_mem_addr, o_valid<=1. Pulse o_pc_advance for exactly one cycle. Go to HOLD.
  - On i_redirect=1 with no ack: go to DRAIN. The memory transaction is never abandoned mid-flight.
  - On i_redirect=1 and i_mem_ack=1 in the same cycle: drop the data and do not pulse advance. Go to IDLE, which re-requests at the new PC when i_en=1.
- DRAIN:
  - o_mem_req stays 1 until i_mem_ack. The returned data is dropped, with no advance and no valid.
  - Then go to IDLE.
  - A further redirect while in DRAIN changes nothing.
- HOLD:
  - o_valid=1; o_instr and o_instr_pc are stable.
  - On i_ready=1 with no redirect: o_valid<=0. If i_en=1, go to REQ with o_mem_addr<=i_pc (the already-advanced PC); otherwise go to IDLE.
  - On i_redirect=1, regardless of i_ready: o_valid<=0 and go to IDLE. The instruction is not delivered.
- Timing:
  - Minimum latency from a REQ-entry edge to o_valid is 1 cycle after the ack edge.
  - Minimum issue interval is ack cycle, HOLD with ready, then REQ: one instruction per 2 cycles at best. This is acceptable.
- o_pc_advance:
  - Pulses only for acknowledged, non-discarded fetches: exactly one pulse per instruction that enters the buffer.
  - Never asserted in the same cycle as i_redirect.
- i_en deassert:
  - Only blocks new requests.
  - Outstanding REQ/DRAIN completes; a buffered instruction stays valid until consumed.
- The instruction buffer holds a single entry; no instruction is overwritten while o_valid=1.
- No arithmetic is performed. The PC increment belongs to the PC block; ADDR_W wrap-around is that block's concern.
- Reset asserted mid-transaction: immediate return to reset values. Memory must tolerate a dropped request.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DRAIN=2'd3) and the ADDR_W/INSTR_W defaults, shared with the PC and decode blocks.
- One natural sub-module, fetch_buf: the single-entry instruction/PC register with valid/ready. The FSM stays in instr_fetch.

Test Plan:
1. Reset, then i_en=1, i_pc=0, memory acks 1 cycle after req with rdata=32'hA0000000 -> o_mem_addr=0, one o_pc_advance pulse, o_valid=1, o_instr=32'hA0000000, o_instr_pc=0.
2. Decode i_ready=0 for 4 cycles, then 1 -> o_valid held and o_instr stable for 4 cycles. No new o_mem_req until the cycle after the handshake, then o_mem_addr=1.
3. i_redirect during REQ before ack (ack arrives 3 cycles later), i_pc then 36'h40 -> req held until ack, data dropped, no advance, o_valid stays 0. Next request has o_mem_addr=36'h40.
4. i_redirect and i_mem_ack in the same cycle -> no o_valid, no o_pc_advance. Next request at the new i_pc.
5. i_redirect while HOLD with i_ready=1 -> instruction not consumed, o_valid=0 next cycle, request at the redirect PC.
6. i_rst_n pulled low mid-REQ -> all outputs 0 asynchronously. After release with i_en=1, fetch restarts at i_pc=0.
